// File: rtl/field_tag_decoder_if.sv
// Byte-in / descriptor-out / payload-out bundle for the protobuf tag decoder.
// slave is the decoder's view; master is the view of whoever drives it.
interface field_tag_decoder_if #(
  parameter int FIELD_ID_W = 16,
  parameter int LEN_W      = 32
);
  logic [7:0]            s_data_i;
  logic                  s_valid_i;
  logic                  s_last_i;
  logic                  s_rdy_o;
  logic [FIELD_ID_W-1:0] field_id_o;
  logic [2:0]            wire_type_o;
  logic [LEN_W-1:0]      length_o;
  logic                  field_id_valid_o;
  logic                  field_id_rdy_i;
  logic [7:0]            m_data_o;
  logic                  m_valid_o;
  logic                  m_last_o;
  logic                  m_rdy_i;
  logic                  err_o;

  modport slave (
    input  s_data_i, s_valid_i, s_last_i, field_id_rdy_i, m_rdy_i,
    output s_rdy_o, field_id_o, wire_type_o, length_o, field_id_valid_o,
           m_data_o, m_valid_o, m_last_o, err_o
  );

  modport master (
    output s_data_i, s_valid_i, s_last_i, field_id_rdy_i, m_rdy_i,
    input  s_rdy_o, field_id_o, wire_type_o, length_o, field_id_valid_o,
           m_data_o, m_valid_o, m_last_o, err_o
  );
endinterface

// File: rtl/field_tag_decoder.sv
// Protobuf key/length varint decoder: descriptor 1 cycle after the terminating byte, payload via a 1-entry skid.
// Input stalls while a descriptor waits for field_id_rdy_i or the payload register is full and not draining.
module field_tag_decoder #(
  parameter int FIELD_ID_W       = 16,
  parameter int LEN_W            = 32,
  parameter int MAX_VARINT_BYTES = 5
) (
  input logic               clk_i,
  input logic               reset_i,
  field_tag_decoder_if.slave bus
);

  localparam int ACC_W = 7 * MAX_VARINT_BYTES;
  localparam int VC_W  = 4;

  typedef enum logic [2:0] {KEY, LEN, DESC, PAYLOAD, DRAIN} state_t;

  state_t                state;
  logic                  live;
  logic [ACC_W-1:0]      acc;
  logic [VC_W-1:0]       vcnt;
  logic [LEN_W-1:0]      cnt;
  logic [FIELD_ID_W-1:0] fid_q;
  logic [2:0]            wt_q;
  logic [LEN_W-1:0]      len_q;
  logic                  desc_vld;
  logic [7:0]            m_dat;
  logic                  m_vld;
  logic                  m_lst;
  logic                  err;

  logic                  s_rdy;
  logic                  take;
  logic                  cont;
  logic [ACC_W-1:0]      acc_nxt;
  logic [2:0]            key_wt;
  logic                  key_wt_ok;
  logic                  fid_zero;
  logic                  fid_ovf;
  logic                  len_ovf;
  logic                  len_nz;
  logic                  vovf;
  logic                  key_bad;
  logic                  len_bad;
  logic                  pay_last;
  logic                  wt0_ovl;

  always_comb begin
    s_rdy = 1'b0;
    case (state)
      KEY, LEN, DRAIN: s_rdy = live;
      PAYLOAD:         s_rdy = live && (!m_vld || bus.m_rdy_i);
      default:         s_rdy = 1'b0;
    endcase
  end

  // Full-width accumulator so over-wide keys/lengths are detected, never truncated.
  always_comb begin
    take      = bus.s_valid_i && s_rdy;
    cont      = bus.s_data_i[7];
    acc_nxt   = acc | (ACC_W'(bus.s_data_i[6:0]) << (7 * vcnt));
    key_wt    = acc_nxt[2:0];
    key_wt_ok = (key_wt == 3'd0) || (key_wt == 3'd1) || (key_wt == 3'd2) || (key_wt == 3'd5);
    fid_zero  = (acc_nxt >> 3) == '0;
    fid_ovf   = (acc_nxt >> (FIELD_ID_W + 3)) != '0;
    len_ovf   = (acc_nxt >> LEN_W) != '0;
    len_nz    = acc_nxt != '0;
    vovf      = vcnt == VC_W'(MAX_VARINT_BYTES);
    key_bad   = vovf || bus.s_last_i || (!cont && (!key_wt_ok || fid_zero || fid_ovf));
    len_bad   = vovf || (!cont && len_ovf) || (bus.s_last_i && (cont || len_nz));
    pay_last  = (wt_q == 3'd0) ? !cont : (cnt == LEN_W'(1));
    wt0_ovl   = (wt_q == 3'd0) && cont && (vcnt == VC_W'(9));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= KEY;
      live     <= 1'b0;
      acc      <= '0;
      vcnt     <= '0;
      cnt      <= '0;
      fid_q    <= '0;
      wt_q     <= '0;
      len_q    <= '0;
      desc_vld <= 1'b0;
      m_dat    <= '0;
      m_vld    <= 1'b0;
      m_lst    <= 1'b0;
      err      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (m_vld && bus.m_rdy_i) begin
        m_vld <= 1'b0;
        m_lst <= 1'b0;
      end
      case (state)
        KEY: if (take) begin
          if (key_bad) begin
            err   <= 1'b1;
            state <= bus.s_last_i ? KEY : DRAIN;
            acc   <= '0;
            vcnt  <= '0;
          end else if (cont) begin
            acc  <= acc_nxt;
            vcnt <= vcnt + 1'b1;
          end else begin
            acc   <= '0;
            vcnt  <= '0;
            fid_q <= acc_nxt[FIELD_ID_W+2:3];
            wt_q  <= key_wt;
            if (key_wt == 3'd2) begin
              state <= LEN;
            end else begin
              len_q    <= (key_wt == 3'd1) ? LEN_W'(8) : (key_wt == 3'd5) ? LEN_W'(4) : '0;
              desc_vld <= 1'b1;
              state    <= DESC;
            end
          end
        end
        LEN: if (take) begin
          if (len_bad) begin
            err   <= 1'b1;
            state <= bus.s_last_i ? KEY : DRAIN;
            acc   <= '0;
            vcnt  <= '0;
          end else if (cont) begin
            acc  <= acc_nxt;
            vcnt <= vcnt + 1'b1;
          end else begin
            acc      <= '0;
            vcnt     <= '0;
            len_q    <= acc_nxt[LEN_W-1:0];
            desc_vld <= 1'b1;
            state    <= DESC;
          end
        end
        DESC: if (bus.field_id_rdy_i) begin
          desc_vld <= 1'b0;
          cnt      <= len_q;
          vcnt     <= '0;
          state    <= ((wt_q == 3'd2) && (len_q == '0)) ? KEY : PAYLOAD;
        end
        PAYLOAD: if (take) begin
          if (wt0_ovl) begin
            err   <= 1'b1;
            vcnt  <= '0;
            state <= bus.s_last_i ? KEY : DRAIN;
          end else begin
            m_dat <= bus.s_data_i;
            m_vld <= 1'b1;
            // A premature s_last still closes the field so downstream is not left open.
            m_lst <= pay_last || bus.s_last_i;
            if (wt_q == 3'd0) vcnt <= vcnt + 1'b1;
            else              cnt  <= cnt - 1'b1;
            if (bus.s_last_i && !pay_last) err <= 1'b1;
            if (pay_last || bus.s_last_i) begin
              vcnt  <= '0;
              state <= KEY;
            end
          end
        end
        DRAIN: if (take && bus.s_last_i) state <= KEY;
        default: state <= KEY;
      endcase
    end
  end

  assign bus.s_rdy_o          = s_rdy;
  assign bus.field_id_o       = fid_q;
  assign bus.wire_type_o      = wt_q;
  assign bus.length_o         = len_q;
  assign bus.field_id_valid_o = desc_vld;
  assign bus.m_data_o         = m_dat;
  assign bus.m_valid_o        = m_vld;
  assign bus.m_last_o         = m_lst;
  assign bus.err_o            = err;

endmodule

// File: tb/tb_field_tag_decoder.sv
// Directed bench for field_tag_decoder: table of single-message vectors plus
// hand-written sequences for error recovery and mid-field reset.
module tb_field_tag_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  field_tag_decoder_if #(.FIELD_ID_W(16), .LEN_W(32)) bus();

  field_tag_decoder #(.FIELD_ID_W(16), .LEN_W(32), .MAX_VARINT_BYTES(5)) dut (
    .clk_i  (clk),
    .reset_i(rst),
    .bus    (bus)
  );

  typedef struct {
    string        name;
    int           nbytes;
    logic [127:0] bytes;   // right-aligned, first byte most significant
    int           last_at;
    int           stall;
    bit           toggle;
    int           lat_idx;
    int           ndesc;
    logic [15:0]  fid;
    logic [2:0]   wt;
    logic [31:0]  len;
    int           npay;
    logic [63:0]  pay;     // right-aligned, first byte most significant
    logic [7:0]   lmask;   // bit i = m_last on payload byte i
    logic         err;
  } vec_t;

  vec_t vt[10];
  vec_t cur;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int stall_left = 0;
  bit toggle = 1'b0;
  bit prev_vld = 1'b0;
  int rise_cyc = -1;
  int acc_idx = 0;
  int acc_cyc[32];

  logic [7:0]  in_d[$];
  bit          in_l[$];
  logic [15:0] d_fid[$];
  logic [2:0]  d_wt[$];
  logic [31:0] d_len[$];
  logic [7:0]  p_dat[$];
  bit          p_lst[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic clr();
    in_d.delete(); in_l.delete();
    d_fid.delete(); d_wt.delete(); d_len.delete();
    p_dat.delete(); p_lst.delete();
    prev_vld = 1'b0;
    rise_cyc = -1;
    acc_idx  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    bus.s_last_i = 1'b0;
    bus.m_rdy_i = 1'b1;
    bus.field_id_rdy_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr();
  endtask

  // One clock: drive at negedge, observe handshakes 1 time unit later.
  task automatic step();
    @(negedge clk);
    cyc++;
    bus.s_valid_i = (in_d.size() > 0);
    bus.s_data_i = 8'h00;
    bus.s_last_i = 1'b0;
    if (in_d.size() > 0) begin
      bus.s_data_i = in_d[0];
      bus.s_last_i = in_l[0];
    end
    bus.m_rdy_i = toggle ? cyc[0] : 1'b1;
    bus.field_id_rdy_i = (stall_left == 0);
    #1;
    if (bus.s_valid_i && bus.s_rdy_o) begin
      if (acc_idx < 32) acc_cyc[acc_idx] = cyc;
      acc_idx++;
      void'(in_d.pop_front());
      void'(in_l.pop_front());
    end
    if (bus.field_id_valid_o && !prev_vld && rise_cyc < 0) rise_cyc = cyc;
    prev_vld = bus.field_id_valid_o;
    if (bus.field_id_valid_o && bus.field_id_rdy_i) begin
      d_fid.push_back(bus.field_id_o);
      d_wt.push_back(bus.wire_type_o);
      d_len.push_back(bus.length_o);
    end else if (bus.field_id_valid_o) begin
      chk({cur.name, " stall fid"}, bus.field_id_o, cur.fid);
      chk({cur.name, " stall wt"}, bus.wire_type_o, cur.wt);
      chk({cur.name, " stall len"}, bus.length_o, cur.len);
      chk({cur.name, " stall s_rdy"}, bus.s_rdy_o, 1'b0);
      if (stall_left > 0) stall_left--;
    end
    if (bus.m_valid_o && bus.m_rdy_i) begin
      p_dat.push_back(bus.m_data_o);
      p_lst.push_back(bus.m_last_o);
    end
  endtask

  task automatic feed(input string nm);
    int guard = 0;
    while (in_d.size() > 0 && guard < 300) begin
      step();
      guard++;
    end
    chk({nm, " input consumed"}, in_d.size(), 0);
    in_d.delete();
    in_l.delete();
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] gmask;
    do_reset();
    cur = v;
    stall_left = v.stall;
    toggle = v.toggle;
    for (int i = 0; i < v.nbytes; i++) begin
      in_d.push_back(v.bytes[8*(v.nbytes-1-i) +: 8]);
      in_l.push_back(i == v.last_at);
    end
    feed(v.name);
    repeat (10) step();
    toggle = 1'b0;
    chk({v.name, " ndesc"}, d_fid.size(), v.ndesc);
    if (v.ndesc > 0 && d_fid.size() > 0) begin
      chk({v.name, " fid"}, d_fid[0], v.fid);
      chk({v.name, " wt"}, d_wt[0], v.wt);
      chk({v.name, " len"}, d_len[0], v.len);
    end
    chk({v.name, " npay"}, p_dat.size(), v.npay);
    gmask = '0;
    for (int i = 0; i < v.npay && i < p_dat.size(); i++) begin
      chk({v.name, " pay byte"}, p_dat[i], v.pay[8*(v.npay-1-i) +: 8]);
      gmask[i] = p_lst[i];
    end
    chk({v.name, " m_last pos"}, gmask, v.lmask);
    chk({v.name, " err"}, bus.err_o, v.err);
    if (v.lat_idx >= 0) chk({v.name, " desc latency"}, rise_cyc, acc_cyc[v.lat_idx] + 1);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " fid_vld"}, bus.field_id_valid_o, 1'b0);
    chk({nm, " m_vld"}, bus.m_valid_o, 1'b0);
    chk({nm, " m_last"}, bus.m_last_o, 1'b0);
    chk({nm, " err"}, bus.err_o, 1'b0);
    chk({nm, " s_rdy"}, bus.s_rdy_o, 1'b0);
    chk({nm, " fid/wt/len/data"}, {bus.field_id_o, bus.wire_type_o, bus.length_o, bus.m_data_o}, '0);
  endtask

  initial begin
    //        name       n  bytes                          last stall tog lat ndesc fid wt len  npay pay                     lmask  err
    vt[0] = '{"wt0",     3, 128'h089601,                   2,  0, 1'b0, 0,  1, 16'd1,  3'd0, 32'd0, 2, 64'h9601,            8'h02, 1'b0};
    vt[1] = '{"wt2",     6, 128'h820103AABBCC,             5,  0, 1'b0, 2,  1, 16'd16, 3'd2, 32'd3, 3, 64'hAABBCC,          8'h04, 1'b0};
    vt[2] = '{"wt5stall",5, 128'h0D01020304,               4,  5, 1'b1, 0,  1, 16'd1,  3'd5, 32'd4, 4, 64'h01020304,        8'h08, 1'b0};
    vt[3] = '{"wt1",     9, 128'h091122334455667788,       8,  0, 1'b0, 0,  1, 16'd1,  3'd1, 32'd8, 8, 64'h1122334455667788,8'h80, 1'b0};
    vt[4] = '{"len0",    2, 128'h1200,                     1,  0, 1'b0, 1,  1, 16'd2,  3'd2, 32'd0, 0, 64'h0,               8'h00, 1'b0};
    vt[5] = '{"fid0",    1, 128'h02,                       0,  0, 1'b0, -1, 0, 16'd0,  3'd0, 32'd0, 0, 64'h0,               8'h00, 1'b1};
    vt[6] = '{"fidovf",  3, 128'h808020,                   2,  0, 1'b0, -1, 0, 16'd0,  3'd0, 32'd0, 0, 64'h0,               8'h00, 1'b1};
    vt[7] = '{"keylong", 6, 128'h808080808001,             5,  0, 1'b0, -1, 0, 16'd0,  3'd0, 32'd0, 0, 64'h0,               8'h00, 1'b1};
    vt[8] = '{"lenovf",  6, 128'h0A8080808010,             5,  0, 1'b0, -1, 0, 16'd0,  3'd0, 32'd0, 0, 64'h0,               8'h00, 1'b1};
    vt[9] = '{"key2byte",3, 128'h880007,                   2,  0, 1'b0, 1,  1, 16'd1,  3'd0, 32'd0, 1, 64'h07,              8'h01, 1'b0};

    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    bus.s_data_i = 8'h00;
    bus.s_last_i = 1'b0;
    bus.m_rdy_i = 1'b1;
    bus.field_id_rdy_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outs("reset");
    cur = vt[0];

    for (int k = 0; k < 10; k++) run_vec(vt[k]);

    // Bad wire type, drain to s_last, then a clean message with err staying set.
    do_reset();
    cur = vt[0];
    in_d = '{8'h0B, 8'h11, 8'h22, 8'h33, 8'h08, 8'h05};
    in_l = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    feed("wt3");
    repeat (8) step();
    chk("wt3 ndesc", d_fid.size(), 1);
    if (d_fid.size() > 0) begin
      chk("wt3 next fid", d_fid[0], 16'd1);
      chk("wt3 next wt", d_wt[0], 3'd0);
    end
    chk("wt3 npay", p_dat.size(), 1);
    if (p_dat.size() > 0) chk("wt3 next pay", {p_lst[0], p_dat[0]}, {1'b1, 8'h05});
    chk("wt3 err sticky", bus.err_o, 1'b1);

    // Reset in the middle of a wt5 payload, then a zero-length wt2 field.
    do_reset();
    in_d = '{8'h0D, 8'h01, 8'h02};
    in_l = '{1'b0, 1'b0, 1'b0};
    feed("midrst");
    repeat (4) step();
    chk("midrst pre npay", p_dat.size(), 2);
    @(negedge clk);
    rst = 1'b1;
    bus.s_valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk_reset_outs("midrst");
    rst = 1'b0;
    clr();
    in_d = '{8'h12, 8'h00};
    in_l = '{1'b0, 1'b1};
    feed("midrst post");
    repeat (8) step();
    chk("midrst ndesc", d_fid.size(), 1);
    if (d_fid.size() > 0) chk("midrst desc", {d_fid[0], d_wt[0], d_len[0]}, {16'd2, 3'd2, 32'd0});
    chk("midrst npay", p_dat.size(), 0);
    chk("midrst err", bus.err_o, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
